// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped data cache: FSM encoding,
// address field widths and address field extraction helpers.
package cache_pkg;

   localparam int INDEX_W  = 3;
   localparam int TAG_W    = 6 - INDEX_W;
   localparam int OFFSET_W = 2;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_WRITEBACK = 2'd1,
      S_FETCH     = 2'd2,
      S_UPDATE    = 2'd3
   } state_e;

   function automatic logic [TAG_W-1:0] get_tag(input logic [7:0] addr);
      return addr[7 -: TAG_W];
   endfunction

   function automatic logic [INDEX_W-1:0] get_index(input logic [7:0] addr);
      return addr[OFFSET_W +: INDEX_W];
   endfunction

   function automatic logic [OFFSET_W-1:0] get_offset(input logic [7:0] addr);
      return addr[OFFSET_W-1:0];
   endfunction

endpackage

// File: rtl/cache_line_store.sv
// Line storage: data/tag arrays (no reset) and valid/dirty bits (cleared on
// reset). One shared index selects the line for reads and all updates.
module cache_line_store import cache_pkg::*; #(
   parameter int INDEX_BITS = INDEX_W,
   parameter int TAG_BITS   = 6 - INDEX_BITS
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [INDEX_BITS-1:0] index_i,
   input  logic                  wr_en_i,
   input  logic [OFFSET_W-1:0]   wr_offset_i,
   input  logic [7:0]            wr_byte_i,
   input  logic                  fill_en_i,
   input  logic [31:0]           fill_data_i,
   input  logic                  install_en_i,
   input  logic [TAG_BITS-1:0]   install_tag_i,
   output logic [31:0]           rd_data_o,
   output logic [TAG_BITS-1:0]   rd_tag_o,
   output logic                  rd_valid_o,
   output logic                  rd_dirty_o
);

   localparam int LINES = 1 << INDEX_BITS;

   logic [LINES-1:0][31:0]         data_q;
   logic [LINES-1:0][TAG_BITS-1:0] tag_q;
   logic [LINES-1:0]               valid_q;
   logic [LINES-1:0]               dirty_q;

   // Data and tag contents: byte stores, block fills and tag installs.
   always_ff @(posedge clk_i) begin
      if (wr_en_i)      data_q[index_i][{wr_offset_i, 3'b000} +: 8] <= wr_byte_i;
      if (fill_en_i)    data_q[index_i] <= fill_data_i;
      if (install_en_i) tag_q[index_i]  <= install_tag_i;
   end

   // Line state: reset invalidates everything; stores dirty, installs clean.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         if (wr_en_i) dirty_q[index_i] <= 1'b1;
         if (install_en_i) begin
            valid_q[index_i] <= 1'b1;
            dirty_q[index_i] <= 1'b0;
         end
      end
   end

   assign rd_data_o  = data_q[index_i];
   assign rd_tag_o   = tag_q[index_i];
   assign rd_valid_o = valid_q[index_i];
   assign rd_dirty_o = dirty_q[index_i];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache. Hits complete with
// zero stall; misses run WRITEBACK (if dirty) -> FETCH -> UPDATE and then the
// held request hits in IDLE.
module data_cache import cache_pkg::*; #(
   parameter int INDEX_BITS = INDEX_W,
   parameter int MEM_ADDR_W = 6
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  READ,
   input  logic                  WRITE,
   input  logic [7:0]            ADDRESS,
   input  logic [7:0]            WRITEDATA,
   output logic [7:0]            READDATA,
   output logic                  BUSYWAIT,
   output logic                  MEM_READ,
   output logic                  MEM_WRITE,
   output logic [MEM_ADDR_W-1:0] MEM_ADDRESS,
   output logic [31:0]           MEM_WRITEDATA,
   input  logic [31:0]           MEM_READDATA,
   input  logic                  MEM_BUSYWAIT
);

   localparam int TAG_BITS = 6 - INDEX_BITS;

   logic [TAG_BITS-1:0]   req_tag;
   logic [INDEX_BITS-1:0] index;
   logic [OFFSET_W-1:0]   offset;
   logic [31:0]           line_data;
   logic [TAG_BITS-1:0]   line_tag;
   logic                  line_valid, line_dirty, hit, idle_hit;
   logic                  wr_en, fill_en, install_en;

   state_e                state_q, state_d;
   logic                  seen_busy_q, seen_busy_d;
   logic                  mem_read_q, mem_read_d;
   logic                  mem_write_q, mem_write_d;
   logic [MEM_ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]           mem_wdata_q, mem_wdata_d;

   assign req_tag = ADDRESS[7 -: TAG_BITS];
   assign index   = ADDRESS[OFFSET_W +: INDEX_BITS];
   assign offset  = get_offset(ADDRESS);

   cache_line_store #(.INDEX_BITS(INDEX_BITS), .TAG_BITS(TAG_BITS)) u_store (
      .clk_i        (CLK),
      .rst_i        (RESET),
      .index_i      (index),
      .wr_en_i      (wr_en),
      .wr_offset_i  (offset),
      .wr_byte_i    (WRITEDATA),
      .fill_en_i    (fill_en),
      .fill_data_i  (MEM_READDATA),
      .install_en_i (install_en),
      .install_tag_i(req_tag),
      .rd_data_o    (line_data),
      .rd_tag_o     (line_tag),
      .rd_valid_o   (line_valid),
      .rd_dirty_o   (line_dirty)
   );

   assign hit      = line_valid && (line_tag == req_tag);
   assign idle_hit = (state_q == S_IDLE) && hit && !RESET;

   // CPU side: a write wins over a simultaneous read; loads return 0 unless hitting.
   assign wr_en    = idle_hit && WRITE;
   assign BUSYWAIT = !RESET && (READ || WRITE) && !((state_q == S_IDLE) && hit);
   assign READDATA = (idle_hit && READ && !WRITE) ? line_data[{offset, 3'b000} +: 8] : 8'h00;

   assign MEM_READ      = mem_read_q;
   assign MEM_WRITE     = mem_write_q;
   assign MEM_ADDRESS   = mem_addr_q;
   assign MEM_WRITEDATA = mem_wdata_q;

   // Miss FSM next state; memory request outputs are set up one edge ahead so
   // they are registered and stable for the whole handshake.
   always_comb begin
      state_d     = state_q;
      seen_busy_d = seen_busy_q;
      mem_read_d  = mem_read_q;
      mem_write_d = mem_write_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      fill_en     = 1'b0;
      install_en  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if ((READ || WRITE) && !hit) begin
               if (line_dirty) begin
                  state_d     = S_WRITEBACK;
                  mem_write_d = 1'b1;
                  mem_addr_d  = {line_tag, index};
                  mem_wdata_d = line_data;
               end else begin
                  state_d    = S_FETCH;
                  mem_read_d = 1'b1;
                  mem_addr_d = {req_tag, index};
               end
            end
         end
         S_WRITEBACK: begin
            if (MEM_BUSYWAIT) seen_busy_d = 1'b1;
            if (seen_busy_q && !MEM_BUSYWAIT) begin
               state_d     = S_FETCH;
               seen_busy_d = 1'b0;
               mem_write_d = 1'b0;
               mem_read_d  = 1'b1;
               mem_addr_d  = {req_tag, index};
            end
         end
         S_FETCH: begin
            if (MEM_BUSYWAIT) seen_busy_d = 1'b1;
            if (seen_busy_q && !MEM_BUSYWAIT) begin
               state_d     = S_UPDATE;
               seen_busy_d = 1'b0;
               mem_read_d  = 1'b0;
               fill_en     = 1'b1;
            end
         end
         S_UPDATE: begin
            install_en = 1'b1;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // FSM and memory-port registers; reset abandons any in-flight transfer.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q     <= S_IDLE;
         seen_busy_q <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         seen_busy_q <= seen_busy_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: table-driven hit vectors plus hand-written
// miss, eviction and reset-during-fetch sequences against a small memory model.
module tb_data_cache;

   logic        CLK = 1'b0;
   logic        RESET, READ, WRITE;
   logic [7:0]  ADDRESS, WRITEDATA, READDATA;
   logic        BUSYWAIT, MEM_READ, MEM_WRITE;
   logic [5:0]  MEM_ADDRESS;
   logic [31:0] MEM_WRITEDATA;
   logic [31:0] MEM_READDATA;
   logic        MEM_BUSYWAIT;

   int checks   = 0;
   int failures = 0;

   always #5 CLK = ~CLK;

   data_cache dut (
      .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE),
      .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA), .READDATA(READDATA),
      .BUSYWAIT(BUSYWAIT), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
      .MEM_ADDRESS(MEM_ADDRESS), .MEM_WRITEDATA(MEM_WRITEDATA),
      .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
   );

   // Memory model: raises busy one edge after a request, holds it 3 edges,
   // completes the access as busy drops, then idles one edge so the cache can
   // retire the request before a new one is accepted.
   logic [31:0] mem [64];
   logic [1:0]  mphase;
   int          mcnt;

   always @(posedge CLK) begin
      if (RESET) begin
         mphase       <= 2'd0;
         mcnt         <= 0;
         MEM_BUSYWAIT <= 1'b0;
         MEM_READDATA <= 32'h0;
         for (int i = 0; i < 64; i++) mem[i] <= {8'hC0, 8'(i), 8'(i), 8'(i)};
         mem[1] <= 32'h44332211;
         mem[9] <= 32'h88776655;
      end else begin
         case (mphase)
            2'd0: if (MEM_READ || MEM_WRITE) begin
               MEM_BUSYWAIT <= 1'b1;
               mcnt         <= 3;
               mphase       <= 2'd1;
            end
            2'd1: begin
               if (mcnt == 1) begin
                  MEM_BUSYWAIT <= 1'b0;
                  if (MEM_WRITE) mem[MEM_ADDRESS] <= MEM_WRITEDATA;
                  else           MEM_READDATA     <= mem[MEM_ADDRESS];
                  mphase <= 2'd2;
               end else begin
                  mcnt <= mcnt - 1;
               end
            end
            default: mphase <= 2'd0;
         endcase
      end
   end

   // Memory read and write requests must be mutually exclusive.
   always @(negedge CLK) begin
      if (MEM_READ === 1'b1 && MEM_WRITE === 1'b1) begin
         failures++;
         $display("FAIL mem_rd_wr_overlap at %0t: MEM_READ=1 MEM_WRITE=1 required not both", $time);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Wait (bounded) for BUSYWAIT to drop; returns edges waited.
   task automatic wait_ready(output int n);
      n = 0;
      while (BUSYWAIT && n < 50) begin
         step();
         n++;
      end
      chk("busywait_timeout", {31'd0, BUSYWAIT}, 32'd0);
   endtask

   typedef struct {
      logic       rd;
      logic       wr;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic       exp_busy;
      logic       chk_rdata;
      logic [7:0] exp_rdata;
      string      name;
   } vec_t;

   vec_t vecs [10];

   task automatic apply_vec(input int i);
      step();
      READ      = vecs[i].rd;
      WRITE     = vecs[i].wr;
      ADDRESS   = vecs[i].addr;
      WRITEDATA = vecs[i].wdata;
      #1;
      chk({vecs[i].name, "_busy"}, {31'd0, BUSYWAIT}, {31'd0, vecs[i].exp_busy});
      chk({vecs[i].name, "_memrd"}, {31'd0, MEM_READ}, 32'd0);
      if (vecs[i].chk_rdata) chk({vecs[i].name, "_rdata"}, {24'd0, READDATA}, {24'd0, vecs[i].exp_rdata});
   endtask

   initial begin
      int n;
      //          rd    wr    addr   wdata  busy  chk   rdata
      vecs[0] = '{1'b1, 1'b0, 8'h07, 8'h00, 1'b0, 1'b1, 8'h44, "hit_rd_07"};
      vecs[1] = '{1'b1, 1'b0, 8'h04, 8'h00, 1'b0, 1'b1, 8'h11, "hit_rd_04"};
      vecs[2] = '{1'b0, 1'b1, 8'h06, 8'hAB, 1'b0, 1'b1, 8'h00, "hit_wr_06"};
      vecs[3] = '{1'b1, 1'b0, 8'h06, 8'h00, 1'b0, 1'b1, 8'hAB, "hit_rd_06"};
      vecs[4] = '{1'b1, 1'b0, 8'h05, 8'h00, 1'b0, 1'b1, 8'h22, "hit_rd_05"};
      vecs[5] = '{1'b0, 1'b0, 8'h05, 8'h00, 1'b0, 1'b1, 8'h00, "no_req"};
      vecs[6] = '{1'b1, 1'b0, 8'h26, 8'h00, 1'b0, 1'b1, 8'h77, "hit_rd_26"};
      vecs[7] = '{1'b1, 1'b1, 8'h24, 8'h5A, 1'b0, 1'b0, 8'h00, "rdwr_24"};
      vecs[8] = '{1'b1, 1'b0, 8'h24, 8'h00, 1'b0, 1'b1, 8'h5A, "hit_rd_24"};
      vecs[9] = '{1'b1, 1'b0, 8'h27, 8'h00, 1'b0, 1'b1, 8'h88, "hit_rd_27"};

      RESET = 1'b1; READ = 1'b0; WRITE = 1'b0; ADDRESS = 8'h00; WRITEDATA = 8'h00;
      step(); step();
      chk("rst_busy",   {31'd0, BUSYWAIT},  32'd0);
      chk("rst_rdata",  {24'd0, READDATA},  32'd0);
      chk("rst_memrd",  {31'd0, MEM_READ},  32'd0);
      chk("rst_memwr",  {31'd0, MEM_WRITE}, 32'd0);
      chk("rst_maddr",  {26'd0, MEM_ADDRESS}, 32'd0);
      chk("rst_mwdata", MEM_WRITEDATA, 32'd0);
      READ = 1'b1;
      #1;
      chk("busy_forced_in_rst", {31'd0, BUSYWAIT}, 32'd0);
      READ = 1'b0;
      step();
      RESET = 1'b0;

      // Cold miss on 0x05: fetch block 1.
      step();
      READ = 1'b1; ADDRESS = 8'h05;
      #1;
      chk("miss1_busy",  {31'd0, BUSYWAIT}, 32'd1);
      chk("miss1_memrd_pre", {31'd0, MEM_READ}, 32'd0);
      step();
      chk("miss1_memrd", {31'd0, MEM_READ},  32'd1);
      chk("miss1_memwr", {31'd0, MEM_WRITE}, 32'd0);
      chk("miss1_maddr", {26'd0, MEM_ADDRESS}, 32'h01);
      wait_ready(n);
      chk("miss1_latency", n, 6);
      chk("miss1_rdata", {24'd0, READDATA}, 32'h22);

      for (int i = 0; i <= 5; i++) apply_vec(i);

      // Conflict miss on 0x25 evicts dirty line 1 (tag 0).
      step();
      READ = 1'b1; WRITE = 1'b0; ADDRESS = 8'h25;
      #1;
      chk("evict_busy", {31'd0, BUSYWAIT}, 32'd1);
      step();
      chk("wb_memwr",  {31'd0, MEM_WRITE}, 32'd1);
      chk("wb_memrd",  {31'd0, MEM_READ},  32'd0);
      chk("wb_maddr",  {26'd0, MEM_ADDRESS}, 32'h01);
      chk("wb_mwdata", MEM_WRITEDATA, 32'h44AB2211);
      n = 0;
      while (!MEM_READ && n < 30) begin
         step();
         n++;
      end
      chk("wb_to_fetch_timeout", {31'd0, MEM_READ}, 32'd1);
      chk("fetch2_memwr", {31'd0, MEM_WRITE}, 32'd0);
      chk("fetch2_maddr", {26'd0, MEM_ADDRESS}, 32'h09);
      chk("wb_mem_contents", mem[1], 32'h44AB2211);
      wait_ready(n);
      chk("evict_rdata", {24'd0, READDATA}, 32'h66);

      for (int i = 6; i <= 9; i++) apply_vec(i);

      // Reset while fetching 0x08 (index 2).
      step();
      READ = 1'b1; WRITE = 1'b0; ADDRESS = 8'h08;
      step();
      chk("rf_memrd", {31'd0, MEM_READ}, 32'd1);
      chk("rf_maddr", {26'd0, MEM_ADDRESS}, 32'h02);
      step();
      RESET = 1'b1;
      #1;
      chk("rf_busy_forced", {31'd0, BUSYWAIT}, 32'd0);
      step();
      chk("rf_memrd_drop", {31'd0, MEM_READ},  32'd0);
      chk("rf_memwr_drop", {31'd0, MEM_WRITE}, 32'd0);
      chk("rf_busy_drop",  {31'd0, BUSYWAIT},  32'd0);
      RESET = 1'b0; READ = 1'b0;
      step();
      READ = 1'b1; ADDRESS = 8'h05;
      #1;
      chk("post_rst_miss", {31'd0, BUSYWAIT}, 32'd1);
      wait_ready(n);
      chk("post_rst_rdata", {24'd0, READDATA}, 32'h22);
      READ = 1'b0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
